// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the round-robin tristate bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN  = 2'b01,
    TURN = 2'b10
  } state_t;

  localparam int N_DEF        = 4;
  localparam int W_DEF        = 16;
  localparam int MAX_HOLD_DEF = 8;

  // Index width, never less than one bit so single-entry ranges still get a signal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester after ptr, wrapping.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_idx,
  output logic          valid
);

  logic [N-1:0] elig;
  assign elig = req & ~mask;

  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    win_idx = '0;
    valid   = 1'b0;
    // k runs 1..N so the previous owner (ptr) is considered last.
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!valid && elig[idx]) begin
        valid    = 1'b1;
        win[idx] = 1'b1;
        win_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin tristate bus arbiter with fairness hold limit.
// BUS_ARB_TURNAROUND_EN inserts an idle TURN cycle between owners; otherwise handoff is direct.
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int W        = W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req,
  input  logic [N*W-1:0]        in_data,
  output logic [N-1:0]          grant,
  output logic [N-1:0]          drive_en,
  output logic [clog2(N)-1:0]   sel,
  output logic                  bus_busy,
  output logic [W-1:0]          bus_data
);

  localparam int IW = clog2(N);
  localparam int HW = clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  state_t        state, state_n;
  logic [N-1:0]  grant_n;
  logic [IW-1:0] sel_n, ptr, ptr_n;
  logic [HW-1:0] hold_cnt, hold_n;

  logic [N-1:0]  pick_mask, pick_win;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic          release_bus, preempt;

`ifdef BUS_ARB_TURNAROUND_EN
  assign pick_mask = '0;
`else
  // Outgoing owner sits out the handoff edge so it cannot immediately re-win.
  assign pick_mask = grant;
`endif

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .mask    (pick_mask),
    .win     (pick_win),
    .win_idx (pick_idx),
    .valid   (pick_valid)
  );

  assign release_bus = !req[sel];
  assign preempt     = (hold_cnt == HOLD_LAST) && |(req & ~grant);

  always_comb begin
    state_n = state;
    grant_n = grant;
    sel_n   = sel;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n = OWN;
          grant_n = pick_win;
          sel_n   = pick_idx;
          ptr_n   = pick_idx;
          hold_n  = '0;
        end
      end
      OWN: begin
        if (release_bus || preempt) begin
          hold_n = '0;
`ifdef BUS_ARB_TURNAROUND_EN
          state_n = TURN;
          grant_n = '0;
`else
          if (pick_valid) begin
            grant_n = pick_win;
            sel_n   = pick_idx;
            ptr_n   = pick_idx;
          end else begin
            state_n = IDLE;
            grant_n = '0;
          end
`endif
        end else if (hold_cnt != HOLD_LAST) begin
          hold_n = hold_cnt + 1'b1;
        end
      end
`ifdef BUS_ARB_TURNAROUND_EN
      TURN: begin
        if (pick_valid) begin
          state_n = OWN;
          grant_n = pick_win;
          sel_n   = pick_idx;
          ptr_n   = pick_idx;
        end else begin
          state_n = IDLE;
        end
      end
`endif
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      sel      <= '0;
      ptr      <= IW'(N - 1);
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      sel      <= sel_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
    end
  end

  logic [W-1:0] slice [N];
  for (genvar i = 0; i < N; i++) begin : g_slice
    assign slice[i] = in_data[i*W +: W];
  end

  assign drive_en = grant;
  assign bus_busy = (state != IDLE);
  assign bus_data = (|grant) ? slice[sel] : '0;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: default instance (MAX_HOLD=8) and a MAX_HOLD=4 instance.
module tb_bus_arbiter_rr;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk, rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   grant, drive_en, grant4, drive_en4;
  logic [1:0]     sel, sel4;
  logic           bus_busy, bus_busy4;
  logic [W-1:0]   bus_data, bus_data4;

  int n_chk  = 0;
  int n_fail = 0;

  bus_arbiter_rr #(.N(N), .W(W), .MAX_HOLD(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .in_data(in_data),
    .grant(grant), .drive_en(drive_en), .sel(sel),
    .bus_busy(bus_busy), .bus_data(bus_data)
  );

  bus_arbiter_rr #(.N(N), .W(W), .MAX_HOLD(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .in_data(in_data),
    .grant(grant4), .drive_en(drive_en4), .sel(sel4),
    .bus_busy(bus_busy4), .bus_data(bus_data4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between clock edges.
  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  localparam logic [15:0] D0 = 16'hA5A5, D1 = 16'hB2B2, D2 = 16'hC3C3, D3 = 16'hD4D4;

  initial begin
    logic [15:0] dexp [4];
    dexp[0] = D0; dexp[1] = D1; dexp[2] = D2; dexp[3] = D3;
    rst_n   = 1'b0;
    req     = '0;
    in_data = {D3, D2, D1, D0};

    // Reset state
    step();
    chk("rst_grant", grant, 0);
    chk("rst_drive", drive_en, 0);
    chk("rst_sel", sel, 0);
    chk("rst_busy", bus_busy, 0);
    chk("rst_data", bus_data, 0);
    rst_n = 1'b1;
    step();
    chk("idle_grant", grant, 0);

    // Single owner
    req = 4'b0001;
    step();
    chk("single_grant", grant, 4'b0001);
    chk("single_drive", drive_en, 4'b0001);
    chk("single_busy", bus_busy, 1);
    chk("single_data", bus_data, D0);
    step();
    chk("single_keep", grant, 4'b0001);
    req = 4'b0000;
    step();
    chk("single_rel_grant", grant, 0);
    chk("single_rel_data", bus_data, 0);
`ifdef BUS_ARB_TURNAROUND_EN
    chk("single_turn_busy", bus_busy, 1);
    step();
`endif
    chk("single_idle_busy", bus_busy, 0);

    // Fairness: all four requesting, each holds 8 cycles in order 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      int o;
      o = r % 4;
      for (int c = 0; c < 8; c++) begin
        step();
        chk($sformatf("fair_r%0d_c%0d", r, c), grant, 32'd1 << o);
        chk("fair_onehot", $countones(drive_en) <= 1, 1);
      end
      chk($sformatf("fair_data_r%0d", r), bus_data, dexp[o]);
      chk($sformatf("fair_sel_r%0d", r), sel, o);
`ifdef BUS_ARB_TURNAROUND_EN
      if (r < 4) begin
        step();
        chk("fair_turn_grant", grant, 0);
        chk("fair_turn_busy", bus_busy, 1);
      end
`endif
    end

    // Preempt with MAX_HOLD=4
    do_reset();
    req = 4'b0001;
    step();
    chk("pre_g0_c0", grant4, 4'b0001);
    req = 4'b0101;
    for (int c = 1; c < 4; c++) begin
      step();
      chk($sformatf("pre_g0_c%0d", c), grant4, 4'b0001);
    end
    step();
`ifdef BUS_ARB_TURNAROUND_EN
    chk("pre_turn_grant", grant4, 0);
    chk("pre_turn_busy", bus_busy4, 1);
    step();
`endif
    chk("pre_g2", grant4, 4'b0100);
    chk("pre_g2_data", bus_data4, D2);
    req = 4'b0001;
    step();
`ifdef BUS_ARB_TURNAROUND_EN
    chk("pre_back_turn", grant4, 0);
    step();
`endif
    chk("pre_back_g0", grant4, 4'b0001);
    chk("pre_back_data", bus_data4, D0);

    // Handoff from owner 0 to pending requester 1
    do_reset();
    req = 4'b0011;
    step();
    chk("hand_g0", grant, 4'b0001);
    req = 4'b0010;
    step();
`ifdef BUS_ARB_TURNAROUND_EN
    chk("hand_turn", grant, 0);
    chk("hand_turn_drive", drive_en, 0);
    step();
`endif
    chk("hand_g1", grant, 4'b0010);
    chk("hand_drive", drive_en, 4'b0010);
    chk("hand_busy", bus_busy, 1);

    // Async reset mid-OWN
    do_reset();
    req = 4'b0100;
    step();
    chk("ar_own", grant, 4'b0100);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_grant", grant, 0);
    chk("ar_drive", drive_en, 0);
    chk("ar_busy", bus_busy, 0);
    chk("ar_sel", sel, 0);
    req = 4'b0101;
    #1;
    rst_n = 1'b1;
    step();
    chk("ar_first", grant, 4'b0001);
    chk("ar_first_data", bus_data, D0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
